// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan byte decoder for the dinosaur game.
// Turns make / break / E0-extended sequences into held-key levels and
// single-cycle action pulses; typematic repeats never re-pulse.
// Handshake: byte_valid is a one-cycle strobe with no back-pressure; the
// matching byte_in is valid in the following cycle, and one byte can be
// accepted every cycle.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int CNT_W          = 22
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       jump_held,
    output logic       duck_held,
    output logic       start_held,
    output logic       jump_pulse,
    output logic       duck_pulse,
    output logic       start_pulse,
    output logic       pause_pulse,
    output logic [7:0] last_code,
    output logic       last_ext,
    output logic       last_break,
    output logic       timeout_pulse,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

    // Bit positions inside the key vector.
    localparam int K_SPACE = 0;
    localparam int K_W     = 1;
    localparam int K_S     = 2;
    localparam int K_ENTER = 3;
    localparam int K_ESC   = 4;
    localparam int K_UP    = 5;
    localparam int K_DOWN  = 6;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             v_q, v_d;
    logic [6:0]       keys_q, keys_d;
    logic             jump_pulse_q, jump_pulse_d;
    logic             duck_pulse_q, duck_pulse_d;
    logic             start_pulse_q, start_pulse_d;
    logic             pause_pulse_q, pause_pulse_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       last_code_q, last_code_d;
    logic             last_ext_q, last_ext_d;
    logic             last_break_q, last_break_d;

    // Decode helpers for the byte being processed this cycle.
    logic       done;
    logic       seq_ext;
    logic       seq_brk;
    logic [6:0] key_sel;
    logic       jump_old, jump_new, duck_old, duck_new;

    // Sequence FSM, timeout counter, key bits and pulse generation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        v_d           = byte_valid;
        keys_d        = keys_q;
        last_code_d   = last_code_q;
        last_ext_d    = last_ext_q;
        last_break_d  = last_break_q;
        timeout_d     = 1'b0;
        done          = 1'b0;
        seq_ext       = 1'b0;
        seq_brk       = 1'b0;
        key_sel       = '0;

        if (v_q) begin
            // Any processed byte restarts the prefix timer.
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (byte_in == 8'hE0) begin
                        state_d = EXT;
                    end else if (byte_in == 8'hF0) begin
                        state_d = BRK;
                    end else if (!(byte_in inside {8'hE1, 8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) begin
                        done = 1'b1;
                    end
                end
                EXT: begin
                    if (byte_in == 8'hF0) begin
                        state_d = EXTBRK;
                    end else if (byte_in != 8'hE0) begin
                        done    = 1'b1;
                        seq_ext = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    done    = 1'b1;
                    seq_brk = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    done    = 1'b1;
                    seq_ext = 1'b1;
                    seq_brk = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end else if (state_q != IDLE) begin
            // A stale prefix is dropped; key bits are left untouched.
            if (cnt_q == TMO_LAST) begin
                state_d   = IDLE;
                cnt_d     = '0;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end

        if (done) begin
            last_code_d  = byte_in;
            last_ext_d   = seq_ext;
            last_break_d = seq_brk;
            case ({seq_ext, byte_in})
                {1'b0, 8'h29}: key_sel[K_SPACE] = 1'b1;
                {1'b0, 8'h1D}: key_sel[K_W]     = 1'b1;
                {1'b0, 8'h1B}: key_sel[K_S]     = 1'b1;
                {1'b0, 8'h5A}: key_sel[K_ENTER] = 1'b1;
                {1'b0, 8'h76}: key_sel[K_ESC]   = 1'b1;
                {1'b1, 8'h75}: key_sel[K_UP]    = 1'b1;
                {1'b1, 8'h72}: key_sel[K_DOWN]  = 1'b1;
                default:       key_sel          = '0;
            endcase
            keys_d = seq_brk ? (keys_q & ~key_sel) : (keys_q | key_sel);
        end

        // Pulses fire on the aggregate level rising, so repeats and a second
        // key of the same action stay silent.
        jump_old      = keys_q[K_SPACE] | keys_q[K_W] | keys_q[K_UP];
        jump_new      = keys_d[K_SPACE] | keys_d[K_W] | keys_d[K_UP];
        duck_old      = keys_q[K_S] | keys_q[K_DOWN];
        duck_new      = keys_d[K_S] | keys_d[K_DOWN];
        jump_pulse_d  = jump_new & ~jump_old;
        duck_pulse_d  = duck_new & ~duck_old;
        start_pulse_d = keys_d[K_ENTER] & ~keys_q[K_ENTER];
        pause_pulse_d = keys_d[K_ESC] & ~keys_q[K_ESC];
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            v_q           <= 1'b0;
            keys_q        <= '0;
            jump_pulse_q  <= 1'b0;
            duck_pulse_q  <= 1'b0;
            start_pulse_q <= 1'b0;
            pause_pulse_q <= 1'b0;
            timeout_q     <= 1'b0;
            last_code_q   <= '0;
            last_ext_q    <= 1'b0;
            last_break_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            v_q           <= v_d;
            keys_q        <= keys_d;
            jump_pulse_q  <= jump_pulse_d;
            duck_pulse_q  <= duck_pulse_d;
            start_pulse_q <= start_pulse_d;
            pause_pulse_q <= pause_pulse_d;
            timeout_q     <= timeout_d;
            last_code_q   <= last_code_d;
            last_ext_q    <= last_ext_d;
            last_break_q  <= last_break_d;
        end
    end

    assign jump_held     = keys_q[K_SPACE] | keys_q[K_W] | keys_q[K_UP];
    assign duck_held     = keys_q[K_S] | keys_q[K_DOWN];
    assign start_held    = keys_q[K_ENTER];
    assign jump_pulse    = jump_pulse_q;
    assign duck_pulse    = duck_pulse_q;
    assign start_pulse   = start_pulse_q;
    assign pause_pulse   = pause_pulse_q;
    assign timeout_pulse = timeout_q;
    assign last_code     = last_code_q;
    assign last_ext      = last_ext_q;
    assign last_break    = last_break_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: byte-level reference model feeding an expected
// queue, and a per-cycle monitor comparing every output.
module tb_ps2_key_decoder;

    localparam int TMO = 100;
    // Packed output vector:
    // [17] jump_held [16] duck_held [15] start_held [14] jump_pulse
    // [13] duck_pulse [12] start_pulse [11] pause_pulse [10:3] last_code
    // [2] last_ext [1] last_break [0] timeout_pulse
    localparam logic [17:0] PMASK = 18'h07801;

    logic       Clock = 1'b0;
    logic       reset = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       jump_held, duck_held, start_held;
    logic       jump_pulse, duck_pulse, start_pulse, pause_pulse;
    logic [7:0] last_code;
    logic       last_ext, last_break, timeout_pulse;
    logic [1:0] state_dbg;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .Clock(Clock), .reset(reset), .byte_valid(byte_valid), .byte_in(byte_in),
        .jump_held(jump_held), .duck_held(duck_held), .start_held(start_held),
        .jump_pulse(jump_pulse), .duck_pulse(duck_pulse),
        .start_pulse(start_pulse), .pause_pulse(pause_pulse),
        .last_code(last_code), .last_ext(last_ext), .last_break(last_break),
        .timeout_pulse(timeout_pulse), .state_dbg(state_dbg)
    );

    // ---------------- clock / cycle count ----------------
    always #5 Clock = ~Clock;

    int   cyc = 0;
    logic sv1 = 1'b0, sv2 = 1'b0;
    always @(posedge Clock) begin
        cyc <= cyc + 1;
        sv1 <= byte_valid;
        sv2 <= sv1;
    end

    // ---------------- reference model ----------------
    int          checks = 0;
    int          failures = 0;
    logic [17:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic        held_m [0:511];
    bit          m_ext, m_brk, m_lext, m_lbrk;
    logic [7:0]  m_code;
    int          tmo_at = -1;
    int          tmo_fired = -1;

    function automatic bit jump_m();
        return held_m[9'h029] | held_m[9'h01D] | held_m[9'h175];
    endfunction
    function automatic bit duck_m();
        return held_m[9'h01B] | held_m[9'h172];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 512; i++) held_m[i] = 1'b0;
        m_ext = 0; m_brk = 0; m_lext = 0; m_lbrk = 0; m_code = 8'h00;
        tmo_at = -1; tmo_fired = -1;
        exp_q.delete();
    endtask

    // Called in the cycle the DUT holds the byte; outputs are due next cycle.
    task automatic model_byte(input logic [7:0] b);
        bit oj, od, os, oe, jp, dp, sp, pp;
        jp = 0; dp = 0; sp = 0; pp = 0;
        if ((m_ext || m_brk) && tmo_at >= 0 && cyc >= tmo_at) begin
            m_ext = 0; m_brk = 0; tmo_fired = tmo_at;
        end
        if (!m_brk && b == 8'hE0) m_ext = 1;
        else if (!m_brk && b == 8'hF0) m_brk = 1;
        else if (!m_ext && !m_brk &&
                 (b == 8'hE1 || b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
        end else begin
            oj = jump_m(); od = duck_m(); os = held_m[9'h05A]; oe = held_m[9'h076];
            held_m[{m_ext, b}] = !m_brk;
            m_code = b; m_lext = m_ext; m_lbrk = m_brk;
            jp = !oj && jump_m();
            dp = !od && duck_m();
            sp = !os && held_m[9'h05A];
            pp = !oe && held_m[9'h076];
            m_ext = 0; m_brk = 0;
        end
        tmo_at = (m_ext || m_brk) ? cyc + 1 + TMO : -1;
        exp_q.push_back({jump_m(), duck_m(), held_m[9'h05A], jp, dp, sp, pp,
                         m_code, m_lext, m_lbrk, 1'b0});
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge Clock);
    endtask

    task automatic do_reset();
        @(posedge Clock); #1;
        reset = 1'b0;
        model_clear();
        idle(2); #1;
        reset = 1'b1;
    endtask

    // Strobes every queued byte back-to-back; byte_in follows one cycle later.
    task automatic flush();
        int n;
        n = tx_q.size();
        for (int i = 0; i <= n; i++) begin
            @(posedge Clock); #1;
            byte_valid = (i < n);
            if (i > 0) begin
                byte_in = tx_q[i-1];
                model_byte(tx_q[i-1]);
            end else begin
                byte_in = 8'($urandom);
            end
        end
        tx_q.delete();
        @(posedge Clock); #1;
        byte_in = 8'($urandom);
    endtask

    task automatic send1(input logic [7:0] b);
        tx_q.push_back(b);
        flush();
        idle(1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [17:0] cur = '0;
    always @(negedge Clock) begin
        logic [17:0] act, expv;
        string       nm;
        if (!reset) begin
            cur = '0;
        end else begin
            act = {jump_held, duck_held, start_held, jump_pulse, duck_pulse,
                   start_pulse, pause_pulse, last_code, last_ext, last_break, timeout_pulse};
            expv = cur;
            nm = "quiet";
            if (sv2) begin
                nm = "byte";
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL byte_no_expect cyc=%0d got=%h", cyc, act);
                end else begin
                    expv = exp_q.pop_front();
                    cur = expv & ~PMASK;
                end
            end
            expv[0] = (tmo_at >= 0 && cyc == tmo_at) || (cyc == tmo_fired);
            checks++;
            if (act !== expv) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, expv);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] pool [13] = '{8'h29, 8'h1D, 8'h1B, 8'h5A, 8'h76, 8'h75, 8'h72,
                              8'hE0, 8'hF0, 8'hFA, 8'h00, 8'h13, 8'hE1};

    initial begin
        model_clear();
        do_reset();
        idle(2);

        // Basic make / break of Space.
        send1(8'h29);
        tx_q = '{8'hF0, 8'h29}; flush(); idle(1);
        // Typematic, second jump key, extended break.
        send1(8'h29); send1(8'h29); send1(8'h29);
        tx_q = '{8'hE0, 8'h75}; flush(); idle(1);
        send1(8'hF0); send1(8'h29);
        tx_q = '{8'hE0, 8'hF0, 8'h75}; flush(); idle(2);
        // Extended Down, then unmapped non-extended 72.
        send1(8'hE0); send1(8'h72);
        send1(8'h72);
        // Prefix timeout, then 75 must be non-extended.
        send1(8'hE0);
        idle(TMO + 5);
        checks++;
        if (state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL tmo_state got=%0d want=0", state_dbg);
        end
        send1(8'h75);
        // Reset between E0 and F0.
        send1(8'hE0);
        do_reset();
        idle(2);
        send1(8'hF0); send1(8'h5A);
        send1(8'h5A);
        send1(8'h76); send1(8'h76);
        // Ignored bytes in IDLE.
        tx_q = '{8'hFA, 8'hAA, 8'h00, 8'hE1, 8'hFE, 8'hFF}; flush(); idle(2);
        // Break of a key not held.
        tx_q = '{8'hF0, 8'h1B}; flush(); idle(1);

        // Randomized bursts.
        repeat (200) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) tx_q.push_back(pool[$urandom_range(0, 12)]);
            flush();
            if ($urandom_range(0, 19) == 0) idle(TMO + 3);
            else idle($urandom_range(0, 3));
        end
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
